// File: rtl/reg_file_8x8_if.sv
// Bus bundle for the 8x8 register file: write port from the ALU result,
// two read ports feeding the ALU operands, plus status outputs.
interface reg_file_8x8_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] IN;
    logic [AW-1:0]    INADDRESS;
    logic             WRITE;
    logic [AW-1:0]    OUT1ADDRESS;
    logic [AW-1:0]    OUT2ADDRESS;
    logic [WIDTH-1:0] OUT1;
    logic [WIDTH-1:0] OUT2;
    logic             UNINIT1;
    logic             UNINIT2;
    logic [7:0]       WRCOUNT;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2, UNINIT1, UNINIT2, WRCOUNT
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2, UNINIT1, UNINIT2, WRCOUNT
    );
endinterface

// File: rtl/reg_file_8x8.sv
// 8x8 register file: clocked writes, combinational reads with write-through
// bypass, per-register written flags and a saturating write counter.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_8x8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic          CLK,
    input logic          RESET,
    reg_file_8x8_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic                        zero_target;
    logic                        wr_fire;
    logic [DEPTH-1:0]            wr_sel;
    logic [DEPTH-1:0][WIDTH-1:0] reg_view;
    logic [DEPTH-1:0]            written_view;
    logic [7:0]                  wrcount_q;
    logic [7:0]                  wrcount_d;
    logic                        bypass1;
    logic                        bypass2;

    // A write only commits (and only bypasses) when it is not swallowed by
    // reset or aimed at the hardwired zero register.
    assign zero_target = ZERO_REG && (bus.INADDRESS == '0);
    assign wr_fire     = bus.WRITE && !RESET && !zero_target;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            assign wr_sel[gi] = wr_fire && (bus.INADDRESS == AW'(gi));

            if (ZERO_REG && gi == 0) begin : g_zero
                assign reg_view[gi]     = '0;
                assign written_view[gi] = 1'b1;
            end else begin : g_store
                logic [WIDTH-1:0] data_q;
                logic             written_q;

                always_ff @(posedge CLK) begin
                    if (RESET) begin
                        data_q    <= '0;
                        written_q <= 1'b0;
                    end else if (wr_sel[gi]) begin
                        data_q    <= bus.IN;
                        written_q <= 1'b1;
                    end
                end

                assign reg_view[gi]     = data_q;
                assign written_view[gi] = written_q;
            end
        end
    endgenerate

    always_comb begin
        wrcount_d = wrcount_q;
        if (wr_fire && wrcount_q != 8'hFF) begin
            wrcount_d = wrcount_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrcount_q <= 8'd0;
        end else begin
            wrcount_q <= wrcount_d;
        end
    end

    assign bypass1 = wr_fire && (bus.OUT1ADDRESS == bus.INADDRESS);
    assign bypass2 = wr_fire && (bus.OUT2ADDRESS == bus.INADDRESS);

    always_comb begin
        bus.OUT1    = reg_view[bus.OUT1ADDRESS];
        bus.UNINIT1 = !written_view[bus.OUT1ADDRESS];
        if (bypass1) begin
            bus.OUT1    = bus.IN;
            bus.UNINIT1 = 1'b0;
        end
    end

    always_comb begin
        bus.OUT2    = reg_view[bus.OUT2ADDRESS];
        bus.UNINIT2 = !written_view[bus.OUT2ADDRESS];
        if (bypass2) begin
            bus.OUT2    = bus.IN;
            bus.UNINIT2 = 1'b0;
        end
    end

    assign bus.WRCOUNT = wrcount_q;
endmodule
